// File: rtl/arb_pkg.sv
// Shared types and helpers for mesh router output-port arbitration.
// Used by the arbiter top, its interface and the round-robin picker.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    localparam int STALL_LIM_DEF = 64;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mesh_port_arbiter_if.sv
// Handshake/data bundle between input FIFOs, the output-port arbiter and the
// downstream FIFO. master = arbiter side, slave = FIFO/environment side.
interface mesh_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int pckg_sz = 40
);
    localparam int IW = idx_w(N_IN);

    logic [N_IN-1:0]         pndng_in;
    logic [N_IN*pckg_sz-1:0] data_in;
    logic [N_IN-1:0]         port_en;
    logic [N_IN-1:0]         pop;
    logic                    dst_full;
    logic                    push;
    logic [pckg_sz-1:0]      data_out;
    logic [IW-1:0]           gnt_idx;
    logic                    busy;
    logic                    stall_err;

    modport master (
        input  pndng_in, data_in, port_en, dst_full,
        output pop, push, data_out, gnt_idx, busy, stall_err
    );

    modport slave (
        output pndng_in, data_in, port_en, dst_full,
        input  pop, push, data_out, gnt_idx, busy, stall_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0,
// take the lowest set bit, then rotate the result back.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [N-1:0] rot;
    logic         found;
    int           k;
    int           sum;

    always_comb begin
        rot   = '0;
        found = 1'b0;
        k     = 0;
        sum   = 0;
        gnt   = '0;
        valid = |req;

        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + int'(ptr)) % N];
        end

        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                k     = i;
                found = 1'b1;
            end
        end

        sum = int'(ptr) + k;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = IW'(sum);
        if (valid) begin
            gnt[sum] = 1'b1;
        end
    end

endmodule

// File: rtl/mesh_port_arbiter.sv
// Round-robin output-port scheduler: pops one packet from the winning input
// FIFO, holds it, and pushes it downstream once the destination has room.
module mesh_port_arbiter
    import arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int pckg_sz   = 40,
    parameter int STALL_LIM = STALL_LIM_DEF
) (
    input logic                 clk,
    input logic                 reset,
    mesh_port_arbiter_if.master bus
);

    localparam int IW = idx_w(N_IN);
    localparam int CW = idx_w(STALL_LIM);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_LIM - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    arb_state_e         state_q,     state_d;
    logic [IW-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [pckg_sz-1:0] hold_q,      hold_d;
    logic [IW-1:0]      gnt_idx_q,   gnt_idx_d;
    logic [CW-1:0]      stall_cnt_q, stall_cnt_d;
    logic               stall_err_q, stall_err_d;

    logic [N_IN-1:0] req;
    logic            pick_vld;
    logic [N_IN-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic [N_IN-1:0] pop_c;
    logic            push_c;

    assign req = bus.pndng_in & bus.port_en;

    rr_pick #(.N(N_IN)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        gnt_idx_d   = gnt_idx_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        pop_c       = '0;
        push_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    pop_c     = pick_gnt;
                    hold_d    = bus.data_in[int'(pick_idx)*pckg_sz +: pckg_sz];
                    gnt_idx_d = pick_idx;
                    rr_ptr_d  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!bus.dst_full) begin
                    push_c      = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = IDLE;
                end else if (stall_cnt_q == CNT_MAX) begin
                    // A release on the limit cycle takes the branch above, so no flag.
                    stall_err_d = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            gnt_idx_q   <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            gnt_idx_q   <= gnt_idx_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // pop is combinational from req, so it must be forced low while reset is held.
    assign bus.pop       = reset ? pop_c : '0;
    assign bus.push      = push_c;
    assign bus.data_out  = hold_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.busy      = (state_q == SEND);
    assign bus.stall_err = stall_err_q;

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Scoreboard bench for mesh_port_arbiter: a packet-level reference model queues
// expected per-cycle status and delivered packets; a monitor compares them.
module tb_mesh_port_arbiter;

    localparam int N   = 4;
    localparam int W   = 40;
    localparam int LIM = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mesh_port_arbiter_if #(.N_IN(N), .pckg_sz(W)) bus ();

    mesh_port_arbiter #(.N_IN(N), .pckg_sz(W), .STALL_LIM(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0] pop;
        logic         push;
        logic         busy;
        logic         stall;
        logic         in_rst;
    } st_t;

    typedef struct {
        logic [W-1:0] d;
        int           idx;
    } pkt_t;

    st_t  st_q[$];
    pkt_t pkt_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: is a packet held, who is next in line, how long stalled.
    bit   m_hold  = 1'b0;
    int   m_ptr   = 0;
    int   m_run   = 0;
    bit   m_stall = 1'b0;

    logic [N*W-1:0] dvec = '0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic cyc(input logic [N-1:0] pnd, input logic [N-1:0] en,
                       input logic full, input logic rn);
        st_t s;
        int  w;
        @(posedge clk);
        #1;
        reset        = rn;
        bus.pndng_in = pnd;
        bus.port_en  = en;
        bus.dst_full = full;
        bus.data_in  = dvec;
        s.pop    = '0;
        s.push   = 1'b0;
        s.busy   = 1'b0;
        s.stall  = m_stall;
        s.in_rst = !rn;
        if (!rn) begin
            m_hold  = 1'b0;
            m_ptr   = 0;
            m_run   = 0;
            m_stall = 1'b0;
            s.stall = 1'b0;
            pkt_q.delete();
        end else if (m_hold) begin
            s.busy = 1'b1;
            if (!full) begin
                s.push = 1'b1;
                m_hold = 1'b0;
                m_run  = 0;
            end else begin
                if (m_run == LIM - 1) m_stall = 1'b1;
                else m_run++;
            end
        end else begin
            w = pick(pnd & en, m_ptr);
            if (w >= 0) begin
                s.pop[w] = 1'b1;
                pkt_q.push_back('{dvec[w*W +: W], w});
                m_hold = 1'b1;
                m_ptr  = (w + 1) % N;
            end
        end
        st_q.push_back(s);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        st_t  s;
        pkt_t p;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("pop",       64'(bus.pop),       64'(s.pop));
            chk("push",      64'(bus.push),      64'(s.push));
            chk("busy",      64'(bus.busy),      64'(s.busy));
            chk("stall_err", 64'(bus.stall_err), 64'(s.stall));
            if (s.in_rst) begin
                chk("rst_data_out", 64'(bus.data_out), 64'd0);
                chk("rst_gnt_idx",  64'(bus.gnt_idx),  64'd0);
            end
            if (bus.push) begin
                if (pkt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_push: got data %0h expected no packet", bus.data_out);
                end else begin
                    p = pkt_q.pop_front();
                    chk("data_out", 64'(bus.data_out), 64'(p.d));
                    chk("gnt_idx",  64'(bus.gnt_idx),  64'(p.idx));
                end
            end
        end
    end

    task automatic seq_data();
        for (int i = 0; i < N; i++) dvec[i*W +: W] = W'(i + 1);
    endtask

    task automatic rand_data();
        logic [63:0] r;
        for (int i = 0; i < N; i++) begin
            r = {$urandom, $urandom};
            dvec[i*W +: W] = r[W-1:0];
        end
    endtask

    initial begin
        bus.pndng_in = '1;
        bus.port_en  = '1;
        bus.dst_full = 1'b0;
        bus.data_in  = '0;

        // Reset held with all inputs pending, then fairness and ordering.
        seq_data();
        repeat (3) cyc(4'b1111, 4'hF, 1'b0, 1'b0);
        repeat (10) cyc(4'b1111, 4'hF, 1'b0, 1'b1);

        // Wrap and skip: grant 2 leaves ptr at 3; only input 1 then requests.
        cyc(4'b0100, 4'hF, 1'b0, 1'b1);
        cyc(4'b0000, 4'hF, 1'b0, 1'b1);
        cyc(4'b0010, 4'hF, 1'b0, 1'b1);
        cyc(4'b0000, 4'hF, 1'b0, 1'b1);

        repeat (8) cyc(4'b1111, 4'b0101, 1'b0, 1'b1);

        // Back-pressure on packet 0xA5 long enough to trip the stall flag.
        cyc(4'b1111, 4'hF, 1'b0, 1'b0);
        dvec = '0;
        dvec[W-1:0] = W'(40'hA5);
        cyc(4'b1111, 4'hF, 1'b0, 1'b1);
        repeat (10) cyc(4'b1111, 4'hF, 1'b1, 1'b1);
        cyc(4'b1111, 4'hF, 1'b0, 1'b1);
        repeat (3) cyc(4'b0000, 4'hF, 1'b0, 1'b1);
        cyc(4'b0000, 4'hF, 1'b0, 1'b0);

        // Release on the exact limit cycle must push without flagging.
        seq_data();
        cyc(4'b0001, 4'hF, 1'b0, 1'b1);
        repeat (LIM - 1) cyc(4'b0000, 4'hF, 1'b1, 1'b1);
        cyc(4'b0000, 4'hF, 1'b0, 1'b1);
        repeat (2) cyc(4'b0000, 4'hF, 1'b0, 1'b1);

        // Reset while a packet is held: it is dropped, nothing pushed.
        cyc(4'b1000, 4'hF, 1'b0, 1'b1);
        repeat (2) cyc(4'b0000, 4'hF, 1'b1, 1'b1);
        cyc(4'b0000, 4'hF, 1'b0, 1'b0);
        repeat (2) cyc(4'b0000, 4'hF, 1'b0, 1'b1);

        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] pnd;
            logic [N-1:0] en;
            logic         full;
            logic         rn;
            rand_data();
            pnd  = N'($urandom);
            en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
            full = ((c / 100) % 3 == 2) ? ($urandom_range(0, 99) < 90)
                                        : ($urandom_range(0, 99) < 30);
            rn   = ($urandom_range(0, 299) != 0);
            cyc(pnd, en, full, rn);
        end

        cyc(4'b0000, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mesh_port_arbiter.md
Name: mesh_port_arbiter

Overview:
- Round-robin scheduler for one mesh router output port.
- Shares the port among N_IN pending-flag input FIFOs (terminal or neighbour) and moves one pckg_sz packet at a time into the downstream FIFO.
- Honours downstream back-pressure, supports per-input enable masking, and flags stalls.
- Sits between the input FIFOs and the output-port FIFO inside each router of mesh_gnrtr.

Parameters:
- N_IN, 4, number of requesting inputs (2..8)
- pckg_sz, 40, packet width in bits
- STALL_LIM, 64, consecutive dst_full cycles in SEND before stall_err sets (>=1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- pndng_in  input  N_IN  input i head packet valid (fall-through FIFO)
- data_in  input  N_IN*pckg_sz  head packets, input i at bits [i*pckg_sz +: pckg_sz]
- port_en  input  N_IN  per-input enable; 0 masks the request
- pop  output  N_IN  one-hot pop to the winning input FIFO
- dst_full  input  1  downstream FIFO full
- push  output  1  push strobe to downstream FIFO
- data_out  output  pckg_sz  packet to downstream FIFO
- gnt_idx  output  $clog2(N_IN)  index of the last granted input
- busy  output  1  high while a packet is held
- stall_err  output  1  sticky stall flag

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, hold register=0, stall_cnt=0.
  - Outputs at reset: pop=0, push=0, data_out=0, gnt_idx=0, busy=0, stall_err=0.
- Request vector: req = pndng_in & port_en.
- FSM states: IDLE, SEND.
- IDLE:
  - If req!=0, select winner w = first set bit of req scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1 .. N_IN-1, 0 .. rr_ptr-1).
  - Assert pop[w]=1 for exactly this cycle (combinational from req and rr_ptr).
  - On the clock edge: hold <= data_in[w], gnt_idx <= w, rr_ptr <= (w+1) mod N_IN, state <= SEND.
  - If req==0: pop=0, stay in IDLE, rr_ptr unchanged.
- SEND:
  - busy=1, data_out=hold.
  - push = !dst_full (combinational).
  - If dst_full=0: next state IDLE, stall_cnt <= 0.
  - If dst_full=1: stay in SEND, stall_cnt increments (saturating).
  - When stall_cnt reaches STALL_LIM-1 and dst_full is still 1, stall_err <= 1 on that edge; it stays set until reset.
  - pop is never asserted in SEND.
- Throughput and latency: at most one packet per 2 cycles. Pop cycle N gives push in cycle N+1 at the earliest.
- data_out holds its last value outside SEND. Consumers qualify it with push.
- port_en changes take effect on the next IDLE decision. A held packet is always delivered, even if its port_en drops.
- Simultaneous events:
  - pndng_in rising in the same cycle as SEND completes is serviced in the following IDLE cycle.
  - dst_full deasserting in the same cycle as stall_cnt hits its limit: push occurs and stall_err is not set.
- Mid-operation reset: a held packet is discarded and nothing is pushed. The upstream FIFO has already popped it, so the loss is accepted and documented.
- Fairness: with all inputs requesting continuously, grant order is 0,1,..,N_IN-1,0,... and no input waits more than N_IN grants.

Decomposition:
- Shared package arb_pkg holds:
  - state enum (IDLE, SEND)
  - localparam function for the index width ($clog2 with a minimum of 1)
  - default STALL_LIM constant
- One sub-module, rr_pick: purely combinational rotate / priority-encode / unrotate.
  - Inputs: req, ptr.
  - Outputs: valid, one-hot grant, index.
  - Reusable by other router output ports.

Test Plan:
- Reset: hold reset=0 for 3 cycles with pndng_in=4'b1111 -> pop=0, push=0, busy=0, stall_err=0, data_out=0 throughout; after release, first pop=4'b0001.
- Fairness: N_IN=4, all pndng_in=1, port_en=4'hF, dst_full=0, data_in[i]=i+1 -> pops on alternate cycles at 0,1,2,3,0.
  - data_out sequence 1,2,3,4,1 on push cycles.
  - gnt_idx follows 0,1,2,3,0.
- Wrap and skip: rr_ptr=3 (after granting input 2), req=4'b0010 -> pop=4'b0010, gnt_idx=1, next rr_ptr=2.
- Masking: pndng_in=4'b1111, port_en=4'b0101 -> only inputs 0 and 2 are ever popped, alternating 0,2,0,2.
- Back-pressure: hold dst_full=1 for 10 cycles after a grant of packet 0xA5 -> push=0 and busy=1 for 10 cycles, no further pops.
  - Release dst_full -> single push with data_out=0xA5.
- Stall: STALL_LIM=8, dst_full held at 1 -> stall_err rises after the 8th full cycle in SEND.
  - stall_err stays 1 after dst_full clears and the packet pushes; it clears only on reset=0.
